uart_rx_unit: RTL and testbench
===============================

Name: uart_rx_unit

Overview:
- UART receiver; the receive-side counterpart of the UART-Tx unit, sharing its configuration encoding (data_length, parity_type, stop_bits, baud_rate).
- Synchronises the serial line, detects the start bit with 16x oversampling, samples each bit at mid-bit and shifts the data in LSB first.
- Checks parity and stop bits, then presents the received byte with status flags and a one-cycle done strobe.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- SYNC_STAGES, 2, flip-flop stages in the rx input synchroniser (minimum 2).

Ports:
- clock  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_in  input  1  serial line; idles high.
- data_length  input  1  0 = 7 data bits, 1 = 8 data bits.
- parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- baud_rate  input  2  00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200 baud.
- data_out  output  8  last received word; bit 7 = 0 in 7-bit mode.
- parity_error  output  1  parity mismatch on the last frame.
- stop_error  output  1  a stop bit sampled low on the last frame.
- break_det  output  1  break condition (see Optional Feature).
- rx_active  output  1  high while a frame is being received.
- rx_done  output  1  one-cycle strobe when a frame completes.

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; tick counter, bit counter and shift register clear; synchroniser flops preset to 1.
- Tick generator:
  - Divisor = CLK_FREQ / (baud × 16), integer-truncated (for example, 325 at 9600 baud with a 50 MHz clock).
  - One-cycle oversample tick at that rate. The counter free-runs and restarts at 0 on start-edge detection.
- Configuration: data_length, parity_type and stop_bits are latched on start detection. Changes mid-frame have no effect on the current frame. baud_rate is read live.
- IDLE:
  - A synchronised rx low (seen SYNC_STAGES cycles after the pin falls) moves the FSM to START.
  - rx_active goes high the same cycle.
- START:
  - After 8 ticks, sample rx.
  - rx high: false start; go to IDLE, rx_active drops, no rx_done, flags unchanged.
  - rx low: go to DATA with the tick count reset.
- DATA:
  - Every 16 ticks, sample rx into the shift register, LSB first.
  - After 7 or 8 samples (per data_length): go to PARITY if parity_type is 01 or 10, otherwise go to STOP.
- PARITY:
  - After 16 ticks, sample rx.
  - Expected bit: even = XOR of the data bits; odd = inverted XOR of the data bits.
  - Mismatch sets a pending parity flag. Then go to STOP.
- STOP:
  - After 16 ticks, sample rx; a low sample sets a pending stop flag.
  - If stop_bits = 1, sample a second stop bit 16 ticks later; either low sample sets the flag.
- DONE (one cycle), entered the cycle after the final stop sample:
  - data_out, parity_error, stop_error and break_det load from the pending values.
  - rx_done = 1 for exactly this cycle; rx_active = 0.
  - Next state is IDLE.
- Outputs hold their values until the next rx_done or reset. Flags clear on a good frame.
- Back-to-back frames: a start edge arriving the cycle after DONE is detected normally. No idle gap is required beyond the stop bits.
- Falling edges on rx while the FSM is outside IDLE are ignored.
- Reset asserted mid-frame aborts the frame immediately; no rx_done follows.
- The line held low continuously produces one frame with stop_error = 1. No further frame starts until rx returns high and falls again.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined: break_det = 1 at rx_done when all data bits, the parity bit (if present) and every stop sample were 0. stop_error is also 1 in that case.
- Undefined: break_det is tied to 0 and the detection logic is removed.

Test Plan:
- 8N1 at 9600 baud, CLK_FREQ = 50 MHz, send 0xA5:
  - rx_done pulses once, about 10 × 16 × 325 cycles after the start edge.
  - data_out = 0xA5; parity_error = 0; stop_error = 0.
- 7E2 at 19200 baud, send 0x35 with correct even parity bit 0 → data_out = 0x35, both flags 0. Repeat with the parity bit flipped to 1 → parity_error = 1.
- 8O1, send 0x00 with parity bit 1 → no error. Then send 0x55 with the stop bit driven low → stop_error = 1, data_out = 0x55.
- rx low pulse of 4 × 16 ticks × 0.1 (a glitch shorter than half a bit) → false start: no rx_done, rx_active returns to 0 within 9 ticks.
- Assert rst in the middle of data bit 3 → all outputs 0 immediately. A following clean frame of 0x3C is received correctly.
- Macro defined, 8N1: hold rx low for 12 bit times → rx_done with data_out = 0x00, stop_error = 1, break_det = 1. Macro undefined → break_det = 0.

Source files
------------

// File: rtl/uart_rx_unit.sv
// Purpose: UART receiver with 16x oversampling, LSB-first data, parity and stop-bit checking.
// Latency: rx_done one cycle after the final stop-bit mid-point sample (plus SYNC_STAGES input sync).
// Backpressure: none; the serial line cannot be stalled and each frame overwrites the output registers.
//
// Ports:
//   clock, rst           - system clock, asynchronous active-high reset
//   rx_in                - serial line, idles high
//   data_length          - 0 = 7 data bits, 1 = 8 data bits (latched at start)
//   parity_type          - 00/11 none, 01 odd, 10 even (latched at start)
//   stop_bits            - 0 = one, 1 = two stop bits (latched at start)
//   baud_rate            - 00 2400, 01 4800, 10 9600, 11 19200 (read live)
//   data_out             - last received word, bit 7 = 0 in 7-bit mode
//   parity_error         - parity mismatch on the last frame
//   stop_error           - a stop bit sampled low on the last frame
//   break_det            - all-zero frame (only with UART_RX_BREAK_DETECT_EN defined, else 0)
//   rx_active            - high while a frame is being received
//   rx_done              - one-cycle strobe when a frame completes
//
// Optional feature macro: UART_RX_BREAK_DETECT_EN
module uart_rx_unit #(
  parameter int CLK_FREQ    = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic [1:0] baud_rate,
  output logic [7:0] data_out,
  output logic       parity_error,
  output logic       stop_error,
  output logic       break_det,
  output logic       rx_active,
  output logic       rx_done
);

  // Oversample divisors; clamped to 1 so tiny clock frequencies still tick.
  localparam int DIV_2400  = (CLK_FREQ / (2400 * 16)  < 1) ? 1 : CLK_FREQ / (2400 * 16);
  localparam int DIV_4800  = (CLK_FREQ / (4800 * 16)  < 1) ? 1 : CLK_FREQ / (4800 * 16);
  localparam int DIV_9600  = (CLK_FREQ / (9600 * 16)  < 1) ? 1 : CLK_FREQ / (9600 * 16);
  localparam int DIV_19200 = (CLK_FREQ / (19200 * 16) < 1) ? 1 : CLK_FREQ / (19200 * 16);
  localparam int CNT_W     = (DIV_2400 > 1) ? $clog2(DIV_2400) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  logic [CNT_W-1:0]       baud_cnt;
  logic [CNT_W-1:0]       div_m1;
  logic                   tick;
  logic [3:0]             os_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   dl_q;
  logic [1:0]             pt_q;
  logic                   sb_q;
  logic                   stop2;
  logic                   par_err_p;
  logic                   stop_err_p;
  logic                   start_det;
  logic                   done_load;
  logic                   parity_en;
  logic                   exp_par;
  logic [7:0]             data_bits;

  // Input synchroniser, preset high so reset never looks like a start bit.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Edge (not level) start detection keeps a stuck-low line from restarting frames.
  assign start_det = (state == IDLE) && !rx_s && rx_prev;

  always_comb begin
    div_m1 = CNT_W'(DIV_9600 - 1);
    case (baud_rate)
      2'b00:   div_m1 = CNT_W'(DIV_2400 - 1);
      2'b01:   div_m1 = CNT_W'(DIV_4800 - 1);
      2'b10:   div_m1 = CNT_W'(DIV_9600 - 1);
      default: div_m1 = CNT_W'(DIV_19200 - 1);
    endcase
  end

  // >= rather than == so a live baud change to a faster rate cannot overshoot the wrap.
  assign tick = (baud_cnt >= div_m1);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if (start_det || tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign parity_en = (pt_q == 2'b01) || (pt_q == 2'b10);
  // In 7-bit mode the word sits in shreg[7:1] after the final shift.
  assign data_bits = dl_q ? shreg : {1'b0, shreg[7:1]};
  assign exp_par   = (pt_q == 2'b01) ? ~(^data_bits) : (^data_bits);
  assign done_load = (state == STOP) && tick && (os_cnt == 4'd15) && !(sb_q && !stop2);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      dl_q         <= 1'b0;
      pt_q         <= 2'b00;
      sb_q         <= 1'b0;
      stop2        <= 1'b0;
      par_err_p    <= 1'b0;
      stop_err_p   <= 1'b0;
      data_out     <= '0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      rx_active    <= 1'b0;
      rx_done      <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) begin
            state      <= START;
            rx_active  <= 1'b1;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            dl_q       <= data_length;
            pt_q       <= parity_type;
            sb_q       <= stop_bits;
            stop2      <= 1'b0;
            par_err_p  <= 1'b0;
            stop_err_p <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt == 4'd7) begin
              os_cnt <= '0;
              if (rx_s) begin
                state     <= IDLE;
                rx_active <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              os_cnt <= '0;
              shreg  <= {rx_s, shreg[7:1]};
              if (bit_cnt == (dl_q ? 3'd7 : 3'd6)) begin
                bit_cnt <= '0;
                state   <= parity_en ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              os_cnt <= '0;
              if (rx_s != exp_par) par_err_p <= 1'b1;
              state <= STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              os_cnt <= '0;
              if (done_load) begin
                // Fold in the final sample directly so the flags are valid during DONE.
                state        <= DONE;
                rx_done      <= 1'b1;
                rx_active    <= 1'b0;
                data_out     <= data_bits;
                parity_error <= par_err_p;
                stop_error   <= stop_err_p | ~rx_s;
              end else begin
                stop2 <= 1'b1;
                if (!rx_s) stop_err_p <= 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          rx_active <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic all_zero;
  logic break_q;
  logic sample_en;

  assign sample_en = tick && (os_cnt == 4'd15) &&
                     ((state == DATA) || (state == PARITY) || (state == STOP));

  // Tracks whether every sampled bit after the start bit has been low.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      all_zero <= 1'b1;
      break_q  <= 1'b0;
    end else begin
      if (start_det) begin
        all_zero <= 1'b1;
      end else if (sample_en && rx_s) begin
        all_zero <= 1'b0;
      end
      if (done_load) break_q <= all_zero && !rx_s;
    end
  end

  assign break_det = break_q;
`else
  assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_unit.sv
// Purpose: directed bench for uart_rx_unit with a reduced clock so frames stay short.
// Latency: checks rx_done timing relative to the start edge of the first frame.
// Backpressure: not applicable; the bench drives the serial line bit by bit.
module tb_uart_rx_unit;

  // 1.2288 MHz gives oversample divisors 32/16/8/4 for 2400/4800/9600/19200 baud.
  localparam int CLK_FREQ = 1228800;
  localparam int BIT96    = 128;
  localparam int BIT192   = 64;

  logic       clock = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       data_length;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic [1:0] baud_rate;
  logic [7:0] data_out;
  logic       parity_error;
  logic       stop_error;
  logic       break_det;
  logic       rx_active;
  logic       rx_done;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cycle    = 0;
  int         done_cnt = 0;
  int         done_cycle = 0;
  logic [7:0] got_q[$];
  logic       exp_brk;

  uart_rx_unit #(.CLK_FREQ(CLK_FREQ), .SYNC_STAGES(2)) dut (
    .clock        (clock),
    .rst          (rst),
    .rx_in        (rx_in),
    .data_length  (data_length),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .baud_rate    (baud_rate),
    .data_out     (data_out),
    .parity_error (parity_error),
    .stop_error   (stop_error),
    .break_det    (break_det),
    .rx_active    (rx_active),
    .rx_done      (rx_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  always @(negedge clock) begin
    if (rx_done) begin
      done_cnt++;
      done_cycle = cycle;
      got_q.push_back(data_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge clock);
  endtask

  // par < 0 means no parity bit; stop_v is driven on every stop bit.
  task automatic send_frame(input logic [7:0] d, input int nd, input int par,
                            input int nstop, input logic stop_v, input int bc);
    send_bit(1'b0, bc);
    for (int i = 0; i < nd; i++) send_bit(d[i], bc);
    if (par >= 0) send_bit(par[0], bc);
    for (int i = 0; i < nstop; i++) send_bit(stop_v, bc);
    rx_in = 1'b1;
  endtask

  initial begin
    int d0;
    int t0;
    int n0;
    int k;
`ifdef UART_RX_BREAK_DETECT_EN
    exp_brk = 1'b1;
`else
    exp_brk = 1'b0;
`endif
    rst         = 1'b1;
    rx_in       = 1'b1;
    data_length = 1'b1;
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    baud_rate   = 2'b10;
    repeat (3) @(negedge clock);
    check("rst_data_out", data_out, 8'h00);
    check("rst_parity_error", parity_error, 1'b0);
    check("rst_stop_error", stop_error, 1'b0);
    check("rst_break_det", break_det, 1'b0);
    check("rst_rx_active", rx_active, 1'b0);
    check("rst_rx_done", rx_done, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clock);

    // 8N1 @ 9600, 0xA5; final stop sample lands 1219 cycles after the pin falls.
    d0 = done_cnt;
    t0 = cycle;
    send_frame(8'hA5, 8, -1, 1, 1'b1, BIT96);
    send_bit(1'b1, BIT96);
    check("a5_done_count", done_cnt - d0, 1);
    check("a5_latency_window", (done_cycle - t0 >= 1200) && (done_cycle - t0 <= 1240), 1'b1);
    check("a5_data", data_out, 8'hA5);
    check("a5_parity_error", parity_error, 1'b0);
    check("a5_stop_error", stop_error, 1'b0);
    check("a5_rx_active", rx_active, 1'b0);

    // Back-to-back frames with no idle gap.
    n0 = got_q.size();
    send_frame(8'h12, 8, -1, 1, 1'b1, BIT96);
    send_frame(8'h34, 8, -1, 1, 1'b1, BIT96);
    send_bit(1'b1, BIT96);
    check("b2b_count", got_q.size() - n0, 2);
    check("b2b_first", got_q[n0], 8'h12);
    check("b2b_second", got_q[n0+1], 8'h34);

    // 7E2 @ 19200: 0x35 has four ones, so even parity bit is 0.
    data_length = 1'b0;
    parity_type = 2'b10;
    stop_bits   = 1'b1;
    baud_rate   = 2'b11;
    send_bit(1'b1, BIT192);
    send_frame(8'h35, 7, 0, 2, 1'b1, BIT192);
    send_bit(1'b1, BIT192);
    check("7e2_data", data_out, 8'h35);
    check("7e2_parity_error", parity_error, 1'b0);
    check("7e2_stop_error", stop_error, 1'b0);
    send_frame(8'h35, 7, 1, 2, 1'b1, BIT192);
    send_bit(1'b1, BIT192);
    check("7e2_bad_par_data", data_out, 8'h35);
    check("7e2_bad_par_flag", parity_error, 1'b1);
    check("7e2_bad_par_stop", stop_error, 1'b0);

    // 8O1 @ 19200: 0x00 and 0x55 both need odd parity bit 1.
    data_length = 1'b1;
    parity_type = 2'b01;
    stop_bits   = 1'b0;
    send_frame(8'h00, 8, 1, 1, 1'b1, BIT192);
    send_bit(1'b1, BIT192);
    check("8o1_zero_data", data_out, 8'h00);
    check("8o1_zero_parity_clears", parity_error, 1'b0);
    check("8o1_zero_stop", stop_error, 1'b0);
    send_frame(8'h55, 8, 1, 1, 1'b0, BIT192);
    send_bit(1'b1, BIT192);
    check("8o1_stop_low_data", data_out, 8'h55);
    check("8o1_stop_low_flag", stop_error, 1'b1);
    check("8o1_stop_low_parity", parity_error, 1'b0);

    // Glitch of ~6.4 ticks at 9600: false start, outputs untouched.
    parity_type = 2'b00;
    baud_rate   = 2'b10;
    send_bit(1'b1, BIT96);
    d0 = done_cnt;
    send_bit(1'b0, 20);
    check("glitch_rx_active_high", rx_active, 1'b1);
    send_bit(1'b0, 31);
    rx_in = 1'b1;
    k = 0;
    while (rx_active && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("glitch_active_drop_in_9_ticks", (k <= 72), 1'b1);
    repeat (2 * BIT96) @(negedge clock);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_data_held", data_out, 8'h55);
    check("glitch_stop_flag_held", stop_error, 1'b1);

    // Reset in the middle of data bit 3 of a 0xFF frame.
    d0 = done_cnt;
    send_bit(1'b0, BIT96);
    for (int i = 0; i < 3; i++) send_bit(1'b1, BIT96);
    send_bit(1'b1, BIT96 / 2);
    check("pre_rst_rx_active", rx_active, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_stop_error", stop_error, 1'b0);
    check("midrst_rx_active", rx_active, 1'b0);
    rx_in = 1'b1;
    repeat (10) @(negedge clock);
    rst = 1'b0;
    repeat (3 * BIT96) @(negedge clock);
    check("midrst_no_done", done_cnt - d0, 0);
    send_frame(8'h3C, 8, -1, 1, 1'b1, BIT96);
    send_bit(1'b1, BIT96);
    check("post_rst_done_count", done_cnt - d0, 1);
    check("post_rst_data", data_out, 8'h3C);
    check("post_rst_stop_error", stop_error, 1'b0);

    // Line held low for 12 bit times at 19200: exactly one frame.
    baud_rate = 2'b11;
    send_bit(1'b1, BIT192);
    d0 = done_cnt;
    send_bit(1'b0, 12 * BIT192);
    check("break_single_done_while_low", done_cnt - d0, 1);
    check("break_data", data_out, 8'h00);
    check("break_stop_error", stop_error, 1'b1);
    check("break_det", break_det, exp_brk);
    check("break_parity_error", parity_error, 1'b0);
    send_bit(1'b1, 2 * BIT192);
    check("break_no_restart", done_cnt - d0, 1);

    // A clean frame afterwards clears break and stop flags.
    send_frame(8'h81, 8, -1, 1, 1'b1, BIT192);
    send_bit(1'b1, BIT192);
    check("after_break_data", data_out, 8'h81);
    check("after_break_det_clear", break_det, 1'b0);
    check("after_break_stop_clear", stop_error, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
